lenet_frame_scheduler: RTL and testbench

- Ping-pong frame scheduler between the ov7670 capture path and the LeNet accelerator.
- Owns two frame buffers and grants one to capture while LeNet reads the other.
- Issues the one-cycle lenet_go with the buffer index and collects the classification result.
- Counts dropped frames and recovers from a hung LeNet with a watchdog.

---
 rtl/lenet_sched_pkg.sv | 21 ++
 rtl/lenet_frame_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_lenet_frame_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lenet_sched_pkg.sv
// Shared types for the LeNet ping-pong frame scheduler.
//   buf_state_t  : lifecycle of one frame buffer
//   ctrl_state_t : LeNet-side control FSM
//   NUM_BUF      : number of frame buffers (ping-pong pair)
package lenet_sched_pkg;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        FULL,
        BUSY
    } buf_state_t;

    typedef enum logic {
        IDLE,
        RUN
    } ctrl_state_t;

    localparam int unsigned NUM_BUF = 2;

endpackage

// File: rtl/lenet_frame_scheduler.sv
// Ping-pong frame scheduler between the ov7670 capture path and the LeNet accelerator.
// Capture fills one buffer while LeNet classifies the other; the oldest completed
// frame is always handed to LeNet first.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   enable         : allow buffer claims and lenet_go
//   frame_start    : capture begins a frame (pulse)
//   frame_done     : capture finished a frame (pulse)
//   wr_allow       : capture may write into wr_buf
//   wr_buf         : buffer index capture writes
//   lenet_ready    : LeNet idle (level)
//   lenet_done     : LeNet finished (pulse), lenet_result valid with it
//   lenet_go       : one-cycle start pulse to LeNet
//   rd_buf         : buffer index LeNet reads, stable from go until done/timeout
//   result         : last captured class
//   result_valid   : one-cycle pulse when result updates
//   drop_cnt       : dropped/aborted frames, saturating
//   timeout_err    : sticky watchdog expiry flag
module lenet_frame_scheduler
    import lenet_sched_pkg::*;
#(
    parameter int unsigned RESULT_W = 4,
    parameter int unsigned TIMEOUT  = 1000000,
    parameter int unsigned DROP_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                frame_start,
    input  logic                frame_done,
    output logic                wr_allow,
    output logic                wr_buf,
    input  logic                lenet_ready,
    input  logic                lenet_done,
    input  logic [RESULT_W-1:0] lenet_result,
    output logic                lenet_go,
    output logic                rd_buf,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid,
    output logic [DROP_W-1:0]   drop_cnt,
    output logic                timeout_err
);

    localparam int unsigned WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    // Watchdog value on the cycle before it would reach TIMEOUT.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    buf_state_t          buf_q [NUM_BUF];
    buf_state_t          buf_d [NUM_BUF];
    ctrl_state_t         ctrl_q, ctrl_d;
    logic                wr_buf_q, wr_buf_d;
    logic                wr_allow_q, wr_allow_d;
    logic                rd_buf_q, rd_buf_d;
    logic                go_q, go_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                rv_q, rv_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                terr_q, terr_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                oldest_q, oldest_d;

    logic                sel;
    logic                done_fill;
    logic                drop;
    buf_state_t          cur_st;

    always_comb begin
        buf_d      = buf_q;
        ctrl_d     = ctrl_q;
        wr_buf_d   = wr_buf_q;
        wr_allow_d = wr_allow_q;
        rd_buf_d   = rd_buf_q;
        go_d       = 1'b0;
        result_d   = result_q;
        rv_d       = 1'b0;
        drop_d     = drop_q;
        terr_d     = terr_q;
        wdog_d     = wdog_q;
        oldest_d   = oldest_q;
        sel        = oldest_q;
        done_fill  = 1'b0;
        drop       = 1'b0;
        cur_st     = buf_q[wr_buf_q];

        // LeNet side works only from registered buffer state.
        unique case (ctrl_q)
            IDLE: begin
                if (enable && lenet_ready && (buf_q[0] == FULL || buf_q[1] == FULL)) begin
                    sel          = (buf_q[oldest_q] == FULL) ? oldest_q : ~oldest_q;
                    buf_d[sel]   = BUSY;
                    rd_buf_d     = sel;
                    go_d         = 1'b1;
                    wdog_d       = '0;
                    ctrl_d       = RUN;
                end
            end
            RUN: begin
                if (lenet_done) begin
                    buf_d[rd_buf_q] = FREE;
                    result_d        = lenet_result;
                    rv_d            = 1'b1;
                    ctrl_d          = IDLE;
                    if (buf_q[~rd_buf_q] == FULL) begin
                        oldest_d = ~rd_buf_q;
                    end
                end else if (TIMEOUT != 0) begin
                    if (wdog_q == WD_LAST) begin
                        buf_d[rd_buf_q] = FREE;
                        terr_d          = 1'b1;
                        ctrl_d          = IDLE;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
        endcase

        // Capture side: frame_done first, then frame_start sees the updated write buffer.
        // A buffer freed by LeNet on this edge is not visible until the next edge.
        if (frame_done && buf_q[wr_buf_q] == FILLING) begin
            done_fill        = 1'b1;
            buf_d[wr_buf_q]  = FULL;
            wr_allow_d       = 1'b0;
            if (buf_q[~wr_buf_q] != FULL) begin
                oldest_d = wr_buf_q;
            end
        end
        cur_st = done_fill ? FULL : buf_q[wr_buf_q];

        if (frame_start && enable) begin
            if (cur_st == FILLING) begin
                // Missing frame_done: restart the same buffer, count the lost frame.
                drop = 1'b1;
            end else if (cur_st == FREE) begin
                buf_d[wr_buf_q] = FILLING;
                wr_allow_d      = 1'b1;
            end else if (buf_q[~wr_buf_q] == FREE) begin
                wr_buf_d         = ~wr_buf_q;
                buf_d[~wr_buf_q] = FILLING;
                wr_allow_d       = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        if (drop && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                buf_q[i] <= FREE;
            end
            ctrl_q     <= IDLE;
            wr_buf_q   <= 1'b0;
            wr_allow_q <= 1'b0;
            rd_buf_q   <= 1'b0;
            go_q       <= 1'b0;
            result_q   <= '0;
            rv_q       <= 1'b0;
            drop_q     <= '0;
            terr_q     <= 1'b0;
            wdog_q     <= '0;
            oldest_q   <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            ctrl_q     <= ctrl_d;
            wr_buf_q   <= wr_buf_d;
            wr_allow_q <= wr_allow_d;
            rd_buf_q   <= rd_buf_d;
            go_q       <= go_d;
            result_q   <= result_d;
            rv_q       <= rv_d;
            drop_q     <= drop_d;
            terr_q     <= terr_d;
            wdog_q     <= wdog_d;
            oldest_q   <= oldest_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_one_filling : assert (!(buf_q[0] == FILLING && buf_q[1] == FILLING));
            a_one_busy    : assert (!(buf_q[0] == BUSY && buf_q[1] == BUSY));
            a_bufs_differ : assert (!(wr_allow_q && ctrl_q == RUN && wr_buf_q == rd_buf_q));
        end
    end

    assign wr_allow     = wr_allow_q;
    assign wr_buf       = wr_buf_q;
    assign rd_buf       = rd_buf_q;
    assign lenet_go     = go_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign drop_cnt     = drop_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_lenet_frame_scheduler.sv
// Bench for lenet_frame_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a buffer/queue reference model.
module tb_lenet_frame_scheduler;

    localparam int TMO = 50;
    localparam int S_FREE = 0, S_FILLING = 1, S_FULL = 2, S_BUSY = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_done = 1'b0;
    logic       wr_allow;
    logic       wr_buf;
    logic       lenet_ready = 1'b0;
    logic       lenet_done = 1'b0;
    logic [3:0] lenet_result = 4'd0;
    logic       lenet_go;
    logic       rd_buf;
    logic [3:0] result;
    logic       result_valid;
    logic [2:0] drop_cnt;
    logic       timeout_err;

    lenet_frame_scheduler #(
        .RESULT_W (4),
        .TIMEOUT  (TMO),
        .DROP_W   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .wr_allow     (wr_allow),
        .wr_buf       (wr_buf),
        .lenet_ready  (lenet_ready),
        .lenet_done   (lenet_done),
        .lenet_result (lenet_result),
        .lenet_go     (lenet_go),
        .rd_buf       (rd_buf),
        .result       (result),
        .result_valid (result_valid),
        .drop_cnt     (drop_cnt),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: buffer states plus a FIFO of completed frames (oldest first).
    int st[2];
    int fq[$];
    int m_wr, m_rd, m_drop, m_age, m_res;
    bit m_go, m_rv, m_terr, m_run, m_wa;

    int auto_lat = 0;     // nonzero: LeNet answers this many cycles after go
    int go_log[$];

    task automatic model(input bit r, input bit en, input bit rdy, input bit fs,
                         input bit fd, input bit dn, input int lres);
        int old[2];
        int b;
        bit lost;
        if (r) begin
            st = '{S_FREE, S_FREE};
            fq.delete();
            m_wr = 0; m_rd = 0; m_drop = 0; m_age = 0; m_res = 0;
            m_go = 0; m_rv = 0; m_terr = 0; m_run = 0; m_wa = 0;
            return;
        end
        old  = st;
        m_go = 0;
        m_rv = 0;
        lost = 0;
        if (!m_run) begin
            if (en && rdy && fq.size() > 0) begin
                b = fq.pop_front();
                st[b] = S_BUSY;
                m_rd = b; m_go = 1; m_run = 1; m_age = 0;
            end
        end else begin
            m_age++;
            if (dn) begin
                st[m_rd] = S_FREE; m_res = lres; m_rv = 1; m_run = 0;
            end else if (m_age == TMO) begin
                st[m_rd] = S_FREE; m_terr = 1; m_run = 0;
            end
        end
        if (fd && old[m_wr] == S_FILLING) begin
            st[m_wr]  = S_FULL;
            old[m_wr] = S_FULL;
            fq.push_back(m_wr);
        end
        if (fs && en) begin
            if (old[m_wr] == S_FILLING) lost = 1;
            else if (old[m_wr] == S_FREE) st[m_wr] = S_FILLING;
            else if (old[1-m_wr] == S_FREE) begin
                m_wr = 1 - m_wr;
                st[m_wr] = S_FILLING;
            end else lost = 1;
        end
        if (lost && m_drop < 7) m_drop++;
        m_wa = (st[m_wr] == S_FILLING);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("wr_allow", {31'd0, wr_allow}, m_wa);
        chk("wr_buf", {31'd0, wr_buf}, m_wr);
        chk("rd_buf", {31'd0, rd_buf}, m_rd);
        chk("lenet_go", {31'd0, lenet_go}, m_go);
        chk("result", {28'd0, result}, m_res);
        chk("result_valid", {31'd0, result_valid}, m_rv);
        chk("drop_cnt", {29'd0, drop_cnt}, m_drop);
        chk("timeout_err", {31'd0, timeout_err}, m_terr);
    endtask

    task automatic step(input bit fs, input bit fd, input bit dn_in, input int lres);
        bit dn;
        dn = dn_in;
        if (auto_lat != 0 && m_run && (m_age + 1 == auto_lat)) dn = 1;
        frame_start  = fs;
        frame_done   = fd;
        lenet_done   = dn;
        lenet_result = 4'(lres);
        @(posedge clk);
        model(rst, enable, lenet_ready, fs, fd, dn, lres & 15);
        #1;
        check_all();
        if (lenet_go === 1'b1) go_log.push_back(int'(rd_buf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, int'($urandom_range(0, 15)));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        chk("rst_wr_allow", {31'd0, wr_allow}, 0);
        chk("rst_drop", {29'd0, drop_cnt}, 0);

        // Basic flow
        enable = 1'b1;
        lenet_ready = 1'b1;
        step(1, 0, 0, 0);
        chk("basic_wr_allow", {31'd0, wr_allow}, 1);
        chk("basic_wr_buf", {31'd0, wr_buf}, 0);
        idle(100);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("basic_go", {31'd0, lenet_go}, 1);
        chk("basic_rd_buf", {31'd0, rd_buf}, 0);
        idle(20);
        step(0, 0, 1, 7);
        chk("basic_result", {28'd0, result}, 7);
        chk("basic_rv", {31'd0, result_valid}, 1);
        step(0, 0, 0, 0);
        chk("basic_rv_pulse", {31'd0, result_valid}, 0);
        step(1, 0, 0, 0);
        chk("basic_buf0_free", {31'd0, wr_buf}, 0);
        chk("basic_reclaim", {31'd0, wr_allow}, 1);
        auto_lat = 10;
        step(0, 1, 0, 0);
        idle(20);

        // Ping-pong, scaled so LeNet (40) fits under the watchdog and beats a frame (50)
        auto_lat = 40;
        go_log.delete();
        for (int f = 0; f < 3; f++) begin
            step(1, 0, 0, 0);
            chk("pp_wr_buf", {31'd0, wr_buf}, (f == 1) ? 1 : 0);
            idle(48);
            step(0, 1, 0, 0);
        end
        idle(60);
        chk("pp_go_count", go_log.size(), 3);
        for (int i = 0; i < 3; i++)
            if (go_log.size() > i) chk("pp_rd_buf", go_log[i], (i == 1) ? 1 : 0);
        chk("pp_drop", {29'd0, drop_cnt}, 0);

        // Overflow: LeNet not ready while four frames arrive
        auto_lat = 20;
        lenet_ready = 1'b0;
        for (int f = 0; f < 4; f++) begin
            step(1, 0, 0, 0);
            if (f == 1) chk("ovf_wr_buf1", {31'd0, wr_buf}, 1);
            idle(10);
            step(0, 1, 0, 0);
        end
        chk("ovf_drop", {29'd0, drop_cnt}, 2);
        lenet_ready = 1'b1;
        step(0, 0, 0, 0);
        chk("ovf_go", {31'd0, lenet_go}, 1);
        chk("ovf_oldest", {31'd0, rd_buf}, 0);
        idle(60);

        // Watchdog: lenet_done exactly on the expiry edge wins
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        auto_lat = 0;
        step(1, 0, 0, 0);
        idle(5);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("wd1_go", {31'd0, lenet_go}, 1);
        idle(TMO - 1);
        step(0, 0, 1, 3);
        chk("wd1_terr", {31'd0, timeout_err}, 0);
        chk("wd1_result", {28'd0, result}, 3);
        // Watchdog expiry with no lenet_done
        step(1, 0, 0, 0);
        idle(5);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("wd2_go", {31'd0, lenet_go}, 1);
        idle(TMO - 1);
        chk("wd2_terr_early", {31'd0, timeout_err}, 0);
        step(0, 0, 0, 0);
        chk("wd2_terr", {31'd0, timeout_err}, 1);
        chk("wd2_result", {28'd0, result}, 3);
        step(1, 0, 0, 0);
        chk("wd2_accept", {31'd0, wr_allow}, 1);
        auto_lat = 10;
        step(0, 1, 0, 0);
        idle(20);

        // Abort, then same-edge frame_done + frame_start
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        auto_lat = 0;
        step(1, 0, 0, 0);
        idle(5);
        step(1, 0, 0, 0);
        chk("abort_drop", {29'd0, drop_cnt}, 1);
        chk("abort_wr_buf", {31'd0, wr_buf}, 0);
        chk("abort_wr_allow", {31'd0, wr_allow}, 1);
        idle(3);
        chk("abort_no_go", {31'd0, lenet_go}, 0);
        step(1, 1, 0, 0);
        chk("same_edge_wr_buf", {31'd0, wr_buf}, 1);
        chk("same_edge_wr_allow", {31'd0, wr_allow}, 1);
        step(0, 0, 0, 0);
        chk("same_edge_go", {31'd0, lenet_go}, 1);
        chk("same_edge_rd", {31'd0, rd_buf}, 0);

        // Reset mid-RUN with buf1 filling
        idle(3);
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        chk("mid_rst_wr_allow", {31'd0, wr_allow}, 0);
        chk("mid_rst_wr_buf", {31'd0, wr_buf}, 0);
        chk("mid_rst_rd_buf", {31'd0, rd_buf}, 0);
        chk("mid_rst_drop", {29'd0, drop_cnt}, 0);
        step(0, 0, 1, 5);
        chk("mid_rst_no_rv", {31'd0, result_valid}, 0);
        chk("mid_rst_result", {28'd0, result}, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 599) == 0);
            enable      = ($urandom_range(0, 9) != 0);
            lenet_ready = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 14) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 24) == 0, int'($urandom_range(0, 15)));
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
